vga_tile_fetch_arbiter: RTL
===========================

// Module: vga_tile_fetch_arbiter
// PURPOSE
//   Shares the single synchronous-read memory port between the CPU and the VGA tile-number fetcher.
//   On each row_start it prefetches one super-pixel row of tile numbers into a double-buffered line buffer.
//   The VGA bit generator reads tile numbers from the front bank by x_sup_pix and never touches memory directly.
//   The VGA fetch has priority; the CPU is served in the remaining port cycles.
// PARAMETERS
//   TILES_PER_ROW  20  tile entries fetched per row (640 px / 32 px super-pixel); must be <= 32
//   FAIR_LIMIT     4   max consecutive VGA grants while the CPU waits (used only with VGA_CPU_FAIR_EN)
// PORTS
//   clk            in   1   single clock; all state updates on its rising edge
//   reset          in   1   asynchronous, active-high reset
//   row_start      in   1   one-cycle pulse: begin fetch of row row_y, and swap banks if the back bank is complete
//   row_y          in   4   super-pixel row index to fetch
//   start_address  in   16  tile-map top-left address (from CPU registers)
//   row_length     in   16  tile-map row pitch, in words
//   x_sup_pix      in   5   display read index into the front bank
//   pic_num        out  9   registered tile number: front[x_sup_pix][8:0]
//   fetch_busy     out  1   high while a row fetch is in progress
//   underrun       out  1   one-cycle pulse: row_start arrived while a fetch was still in progress
//   cpu_req        in   1   CPU access request; held until cpu_ack
//   cpu_we         in   1   1 = write, 0 = read
//   cpu_addr       in   16  CPU address
//   cpu_wdata      in   16  CPU write data
//   cpu_ack        out  1   one-cycle pulse: access complete
//   cpu_rdata      out  16  read data; valid while cpu_ack is high
//   mem_addr       out  16  memory address (combinational from the grant)
//   mem_we         out  1   memory write enable
//   mem_wdata      out  16  memory write data
//   mem_rdata      in   16  memory read data; valid 1 cycle after mem_addr
// BEHAVIOUR
//   Reset values
//   - Outputs: pic_num=0, fetch_busy=0, underrun=0, cpu_ack=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   - Internal: state=IDLE, front bank=0, back_valid=0, fairness counter=0.
//   - Line-buffer RAM is not reset.
//   FSM states
//   - IDLE
//   - FETCH: issuing addresses.
//   - DRAIN: last address issued; waiting one cycle for its data.
//   On row_start
//   - row_base <= start_address + row_y*row_length (16-bit, modulo 2^16); issue index i <= 0; go to FETCH.
//   - If state is IDLE and back_valid=1: swap front/back banks, then clear back_valid.
//   - If state is FETCH or DRAIN: pulse underrun, do not swap, discard the partial fetch, restart the fetch.
//   - The first row_start after reset (back_valid=0, state IDLE): no swap, no underrun.
//   FETCH
//   - Each VGA-granted cycle: mem_addr = row_base + i (modulo 2^16), mem_we=0, i++.
//   - The returned mem_rdata is written to back[i_d] on the next cycle.
//   - After index TILES_PER_ROW-1 is issued: go to DRAIN.
//   - DRAIN -> IDLE with back_valid=1 once the last word is written.
//   - fetch_busy=1 in FETCH and DRAIN.
//   - Nominal latency from row_start to back_valid is TILES_PER_ROW+1 cycles, plus one cycle per CPU grant.
//   Arbitration (evaluated each cycle)
//   - In FETCH with issues remaining, VGA owns the port.
//   - Otherwise the CPU is granted if cpu_req=1 and cpu_ack=0 (at most one CPU access per 2 cycles).
//   - CPU grant: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
//   - cpu_ack is asserted the next cycle; on a read, cpu_rdata <= mem_rdata in that same cycle.
//   - The CPU may be granted in DRAIN; the VGA data write-back is unaffected.
//   - With no grant: mem_we=0, mem_addr holds its last value.
//   pic_num
//   - pic_num <= front[x_sup_pix][8:0], one-cycle latency.
//   - If x_sup_pix >= TILES_PER_ROW: pic_num <= 0.
//   Reset mid-operation
//   - Any state returns immediately to IDLE; a pending cpu_ack is dropped.
//   - The CPU must reissue its request after reset.
// CONFIGURATION
//   VGA_CPU_FAIR_EN defined
//   - Count consecutive VGA grants while cpu_req=1.
//   - When the count reaches FAIR_LIMIT, grant the CPU for one cycle, stall VGA issue (i held), and clear the count.
//   - Fetch latency grows accordingly.
//   VGA_CPU_FAIR_EN undefined
//   - Strict VGA priority; the CPU waits up to TILES_PER_ROW cycles.
//   - The counter logic is absent.
// TESTING
//   1. start_address=0x0100, row_length=20, row_y=2, row_start, mem returns addr[8:0]:
//      mem_addr 0x0128..0x013B on consecutive cycles; fetch_busy low after 21 cycles;
//      next row_start swaps banks; x_sup_pix=5 -> pic_num=0x12D.
//   2. row_start again 10 cycles into a fetch:
//      underrun pulses once; no swap; addresses restart at the new row_base.
//   3. CPU read of 0x0200 in IDLE (mem returns 0xBEEF):
//      mem_addr=0x0200 in the grant cycle; next cycle cpu_ack=1 with cpu_rdata=0xBEEF.
//   4. cpu_req write held through a fetch (fair off):
//      mem_we rises only in the first cycle after the last VGA issue; cpu_ack the following cycle.
//   5. Same as 4 with VGA_CPU_FAIR_EN, FAIR_LIMIT=4:
//      CPU granted after 4 VGA issues; fetch done at cycle 22; tile data intact.
//   6. start_address=0xFFF0, row_y=0, row_length=0:
//      mem_addr wraps 0xFFFF -> 0x0000; x_sup_pix=25 -> pic_num=0; async reset mid-fetch -> fetch_busy=0 immediately.

Source files
------------

// File: rtl/vga_tile_fetch_arbiter_if.sv
// Shared memory-port bus for vga_tile_fetch_arbiter.
// Carries the CPU request/acknowledge bus and the synchronous-read memory port.
// slave  : the arbiter's view (serves the CPU, drives the memory port)
// master : the environment's view (the CPU issuing requests, the memory returning data)
interface vga_tile_fetch_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_tile_fetch_arbiter.sv
// Tile-number fetch arbiter: shares one synchronous-read memory port between the
// CPU and a per-row VGA prefetch into a double-buffered line buffer. The VGA fetch
// has priority; the CPU uses the leftover port cycles.
// Optional feature macro: VGA_CPU_FAIR_EN -- after FAIR_LIMIT consecutive VGA
// grants with the CPU waiting, one port cycle is handed to the CPU.
module vga_tile_fetch_arbiter #(
  parameter int TILES_PER_ROW = 20,  // must be <= 32
  parameter int FAIR_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        row_start,
  input  logic [3:0]  row_y,
  input  logic [15:0] start_address,
  input  logic [15:0] row_length,
  input  logic [4:0]  x_sup_pix,
  output logic [8:0]  pic_num,
  output logic        fetch_busy,
  output logic        underrun,
  vga_tile_fetch_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetchStateT;

  localparam logic [4:0] LAST_IDX = 5'(TILES_PER_ROW - 1);

  fetchStateT  state, stateNext;
  logic [15:0] rowBase;
  logic [4:0]  issueIdx;     // next tile index to issue
  logic [4:0]  wrIdx;        // index of the word returning this cycle
  logic        wrPending;    // memory data this cycle belongs to the VGA fetch
  logic        frontBank;    // bank currently displayed
  logic        backValid;    // back bank holds a complete row
  logic        ackRead;      // the access being acknowledged is a read
  logic [15:0] lastAddr;
  logic [15:0] lastWdata;
  logic [15:0] rdataHold;
  logic        vgaGrant;
  logic        cpuGrant;
  logic        fairStall;
  logic [8:0]  lineBuf [64];  // {bank, index}

`ifdef VGA_CPU_FAIR_EN
  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

  logic [FAIR_W-1:0] fairCnt;

  // The CPU steals one cycle once the VGA has won FAIR_LIMIT times in a row.
  assign fairStall = (fairCnt == FAIR_MAX) && bus.cpu_req && !bus.cpu_ack;

  // Count consecutive VGA wins while the CPU is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fairCnt <= '0;
    else if (cpuGrant || !bus.cpu_req)
      fairCnt <= '0;
    else if (vgaGrant && fairCnt != FAIR_MAX)
      fairCnt <= fairCnt + 1'b1;
  end
`else
  // Fairness limit has no effect in strict-priority builds.
  localparam int fairLimit_unused = FAIR_LIMIT;
  assign fairStall = 1'b0;
`endif

  assign vgaGrant   = (state == FETCH) && !fairStall;
  assign cpuGrant   = !vgaGrant && bus.cpu_req && !bus.cpu_ack;
  assign fetch_busy = (state != IDLE);
  // Read data is only valid in the ack cycle, so it comes straight off the memory then.
  assign bus.cpu_rdata = (bus.cpu_ack && ackRead) ? bus.mem_rdata : rdataHold;

  // State register.
  // NOTE: sequential state always uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state: row_start always (re)starts a fetch; FETCH drains after the last issue.
  // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    stateNext = state;
    if (row_start) begin
      stateNext = FETCH;
    end else begin
      case (state)
        FETCH:   if (vgaGrant && issueIdx == LAST_IDX) stateNext = DRAIN;
        DRAIN:   stateNext = IDLE;
        default: stateNext = state;
      endcase
    end
  end

  // Memory port mux: VGA issue, CPU access, or hold the last address with writes off.
  always_comb begin
    bus.mem_addr  = lastAddr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = lastWdata;
    if (vgaGrant) begin
      bus.mem_addr = rowBase + 16'(issueIdx);
    end else if (cpuGrant) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = bus.cpu_we;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // Fetch sequencing, bank swap and underrun detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rowBase   <= '0;
      issueIdx  <= '0;
      wrIdx     <= '0;
      wrPending <= 1'b0;
      frontBank <= 1'b0;
      backValid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun  <= row_start && (state != IDLE);
      wrPending <= vgaGrant && !row_start;  // a restart discards the in-flight word
      wrIdx     <= issueIdx;
      if (row_start) begin
        rowBase  <= start_address + ({12'd0, row_y} * row_length);
        issueIdx <= '0;
        if (state == IDLE && backValid) begin
          frontBank <= ~frontBank;
          backValid <= 1'b0;
        end
      end else begin
        if (vgaGrant)         issueIdx  <= issueIdx + 1'b1;
        if (state == DRAIN)   backValid <= 1'b1;
      end
    end
  end

  // CPU acknowledge and held port values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_ack <= 1'b0;
      ackRead     <= 1'b0;
      rdataHold   <= '0;
      lastAddr    <= '0;
      lastWdata   <= '0;
    end else begin
      bus.cpu_ack <= cpuGrant;
      ackRead     <= cpuGrant && !bus.cpu_we;
      rdataHold   <= bus.cpu_rdata;
      lastAddr    <= bus.mem_addr;
      lastWdata   <= bus.mem_wdata;
    end
  end

  // Line-buffer write of returning tile numbers into the back bank.
  // NOTE: the line buffer has no reset so it maps onto RAM; rows are fully written before display.
  always_ff @(posedge clk) begin
    if (wrPending) lineBuf[{~frontBank, wrIdx}] <= bus.mem_rdata[8:0];
  end

  // Registered display read from the front bank; out-of-row indices read as 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    pic_num <= '0;
    else if (x_sup_pix <= LAST_IDX) pic_num <= lineBuf[{frontBank, x_sup_pix}];
    else                          pic_num <= '0;
  end

endmodule
